tcp_rx_notify_reader: RTL and testbench
=======================================

# tcp_rx_notify_reader

Receive-side front end between the TCP offload engine and the packet sender.
- Accepts TCP data-available notifications and queues them.
- Issues one read-package request per queued notification.
- Forwards the returned payload beats with the 88-bit notification metadata attached, as {tlast, metadata, data} on a single 601-bit stream to the downstream sender.

## Interface
Parameters:
- NOTIF_DEPTH, 4: notification FIFO depth; power of two, 2..16.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_notifications_TDATA  in  88  [15:0] session, [31:16] length (bytes), [63:32] IP, [79:64] port, [80] closed.
- s_axis_notifications_TVALID  in  1.
- s_axis_notifications_TREADY  out  1.
- m_axis_read_package_TDATA  out  32  [15:0] session, [31:16] length.
- m_axis_read_package_TVALID  out  1.
- m_axis_read_package_TREADY  in  1.
- s_axis_rx_data_TDATA  in  512.
- s_axis_rx_data_TLAST  in  1.
- s_axis_rx_data_TVALID  in  1.
- s_axis_rx_data_TREADY  out  1.
- pkt_tx_TDATA  out  601  [511:0] data, [599:512] notification, [600] tlast.
- pkt_tx_TVALID  out  1.
- pkt_tx_TREADY  in  1.
- len_err  out  1  sticky length-mismatch flag.
- len_err_cnt  out  16  saturating mismatch count.

## Operation
- Notification intake:
  - s_axis_notifications_TREADY = FIFO not full.
  - On handshake, a notification with length != 0 is pushed.
  - A notification with length == 0 (including pure close notifications) is consumed and discarded.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into a 88-bit meta register, load beat_exp = (length+63)>>6 (11 bits), clear beat_cnt, go to REQ.
  - REQ: m_axis_read_package_TVALID=1, TDATA={meta[31:16], meta[15:0]}, held stable until TREADY. Handshake goes to DATA.
  - DATA: combinational pass-through.
    - pkt_tx_TVALID = s_axis_rx_data_TVALID.
    - s_axis_rx_data_TREADY = pkt_tx_TREADY.
    - pkt_tx_TDATA = {TLAST, meta, TDATA}.
    - Each handshake increments beat_cnt.
    - A handshake with TLAST=1 returns to IDLE.
  - Outside DATA: s_axis_rx_data_TREADY=0 and pkt_tx_TVALID=0; rx data is never dropped.
- Only one read request is outstanding at a time; the next is issued only after the previous tlast.
- Length check (see Configuration): a mismatch is TLAST on a beat whose number (beat_cnt+1) != beat_exp.
  - Payload is forwarded unmodified regardless.
  - The FSM still waits for TLAST before leaving DATA.

## Timing
- Reset values:
  - All TVALID outputs and s_axis_rx_data_TREADY: 0.
  - s_axis_notifications_TREADY: 0 during rst, 1 from the first cycle after release.
  - m_axis_read_package_TDATA, len_err, len_err_cnt: 0.
  - FSM in IDLE, FIFO empty.
- Latency: notification handshake in cycle N, FIFO previously empty, FSM in IDLE → read request TVALID high in cycle N+2.
- Data path latency: 0 cycles (combinational).
- IDLE→REQ→DATA; tlast handshake in cycle M → FSM in IDLE at M+1 → next request TVALID at M+2 if the FIFO is non-empty.
- Simultaneous push and pop in one cycle are both honoured; the full flag accounts for the pop, so TREADY stays high at full-with-pop only if the implementation computes it registered from the post-update count (required: registered, conservative, i.e. TREADY=0 whenever count==NOTIF_DEPTH).
- Pointers wrap modulo NOTIF_DEPTH.
- rst asserted mid-packet: state, FIFO and counters clear immediately. The remainder of the packet is not consumed until a new request is issued.
- len_err_cnt saturates at 16'hFFFF.

## Configuration
- Macro RX_LEN_CHECK_EN.
- Defined: beat_exp/beat_cnt comparison active. len_err sets on the first mismatch and clears only on rst. len_err_cnt increments once per mismatching packet.
- Undefined: no comparison logic. len_err and len_err_cnt are tied to 0. The FSM still terminates on TLAST.

## Test plan
- Single notification session=0x0001, length=128 → read request TDATA=0x00800001 at N+2; two rx beats forwarded with TDATA[599:512]=notification, bit600=1 only on beat 2; len_err=0.
- Notification length=0, closed=1 → consumed, no read request issued, FIFO count unchanged.
- Five notifications back-to-back with read TREADY held low, NOTIF_DEPTH=4 → FSM holds the first in REQ and the FIFO fills with the next four. Notification TREADY drops only if a sixth is offered. All five requests are then issued in order.
- pkt_tx_TREADY toggled 1/0 every cycle during a 4-beat (length=256) packet → s_axis_rx_data_TREADY mirrors it, no beat lost or duplicated.
- With RX_LEN_CHECK_EN, length=200 (beat_exp=4) but TLAST on beat 3 → len_err=1, len_err_cnt=1, all 3 beats forwarded; without the macro both stay 0.
- rst pulsed while in DATA after beat 1 of 3 → all outputs at reset values next cycle; a new notification afterwards produces a fresh request at N+2.

Source files
------------

// File: rtl/tcp_rx_notify_reader_if.sv
// Stream bundle around tcp_rx_notify_reader: notification intake, read-package requests,
// returned rx payload and the combined {tlast, metadata, data} stream. The block uses "slave".
interface tcp_rx_notify_reader_if;
    logic [87:0]  s_axis_notifications_TDATA;
    logic         s_axis_notifications_TVALID;
    logic         s_axis_notifications_TREADY;

    logic [31:0]  m_axis_read_package_TDATA;
    logic         m_axis_read_package_TVALID;
    logic         m_axis_read_package_TREADY;

    logic [511:0] s_axis_rx_data_TDATA;
    logic         s_axis_rx_data_TLAST;
    logic         s_axis_rx_data_TVALID;
    logic         s_axis_rx_data_TREADY;

    logic [600:0] pkt_tx_TDATA;
    logic         pkt_tx_TVALID;
    logic         pkt_tx_TREADY;

    modport slave (
        input  s_axis_notifications_TDATA,
        input  s_axis_notifications_TVALID,
        output s_axis_notifications_TREADY,
        output m_axis_read_package_TDATA,
        output m_axis_read_package_TVALID,
        input  m_axis_read_package_TREADY,
        input  s_axis_rx_data_TDATA,
        input  s_axis_rx_data_TLAST,
        input  s_axis_rx_data_TVALID,
        output s_axis_rx_data_TREADY,
        output pkt_tx_TDATA,
        output pkt_tx_TVALID,
        input  pkt_tx_TREADY
    );

    modport master (
        output s_axis_notifications_TDATA,
        output s_axis_notifications_TVALID,
        input  s_axis_notifications_TREADY,
        input  m_axis_read_package_TDATA,
        input  m_axis_read_package_TVALID,
        output m_axis_read_package_TREADY,
        output s_axis_rx_data_TDATA,
        output s_axis_rx_data_TLAST,
        output s_axis_rx_data_TVALID,
        input  s_axis_rx_data_TREADY,
        input  pkt_tx_TDATA,
        input  pkt_tx_TVALID,
        output pkt_tx_TREADY
    );
endinterface

// File: rtl/tcp_rx_notify_reader.sv
// Queues TCP rx notifications, requests one package per notification and forwards the payload
// tagged with its notification. Optional length check enabled by defining RX_LEN_CHECK_EN.
module tcp_rx_notify_reader #(
    parameter int NOTIF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    tcp_rx_notify_reader_if.slave  bus,
    output logic                   len_err,
    output logic [15:0]            len_err_cnt
);

    localparam int AW = (NOTIF_DEPTH > 1) ? $clog2(NOTIF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(NOTIF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        state;
    logic [87:0]   fifo_mem [NOTIF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          notif_rdy;
    logic          push;
    logic          pop;
    logic [87:0]   head;
    logic [87:0]   meta;
    logic          rd_vld;
    logic [31:0]   rd_data;
    logic          in_data;
    logic          rx_hs;

    assign head    = fifo_mem[rd_ptr];
    assign in_data = (state == S_DATA);

    // Zero-length notifications (pure closes included) are accepted but never queued.
    assign push = bus.s_axis_notifications_TVALID & notif_rdy &
                  (bus.s_axis_notifications_TDATA[31:16] != 16'd0);
    assign pop  = (state == S_IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            notif_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            // Registered from the post-update count: never ready while full.
            notif_rdy <= (count_nxt != DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.s_axis_notifications_TDATA;
        if (pop)  meta <= head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rd_vld  <= 1'b1;
                        rd_data <= {head[31:16], head[15:0]};
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.m_axis_read_package_TREADY) begin
                        rd_vld <= 1'b0;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_hs && bus.s_axis_rx_data_TLAST) state <= S_IDLE;
                end
                default: begin
                    rd_vld <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.s_axis_notifications_TREADY = notif_rdy;
    assign bus.m_axis_read_package_TVALID  = rd_vld;
    assign bus.m_axis_read_package_TDATA   = rd_data;

    // Payload passes straight through while a request is being answered.
    assign rx_hs                     = in_data & bus.s_axis_rx_data_TVALID & bus.pkt_tx_TREADY;
    assign bus.s_axis_rx_data_TREADY = in_data & bus.pkt_tx_TREADY;
    assign bus.pkt_tx_TVALID         = in_data & bus.s_axis_rx_data_TVALID;
    assign bus.pkt_tx_TDATA          = {bus.s_axis_rx_data_TLAST, meta, bus.s_axis_rx_data_TDATA};

`ifdef RX_LEN_CHECK_EN
    logic [10:0] beat_exp;
    logic [10:0] beat_cnt;

    function automatic logic [10:0] beats_for(input logic [15:0] len);
        return 11'(({1'b0, len} + 17'd63) >> 6);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_exp    <= '0;
            beat_cnt    <= '0;
            len_err     <= 1'b0;
            len_err_cnt <= '0;
        end else if (pop) begin
            beat_exp <= beats_for(head[31:16]);
            beat_cnt <= '0;
        end else if (rx_hs) begin
            beat_cnt <= beat_cnt + 11'd1;
            // One tlast per packet, so this counts mismatching packets.
            if (bus.s_axis_rx_data_TLAST && ((beat_cnt + 11'd1) != beat_exp)) begin
                len_err <= 1'b1;
                if (len_err_cnt != 16'hFFFF) len_err_cnt <= len_err_cnt + 16'd1;
            end
        end
    end
`else
    assign len_err     = 1'b0;
    assign len_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tcp_rx_notify_reader.sv
// Directed bench for tcp_rx_notify_reader with a queue-based scoreboard for read requests
// and forwarded beats; length-check expectations follow RX_LEN_CHECK_EN.
module tb_tcp_rx_notify_reader;
  localparam int DEPTH = 4;
`ifdef RX_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        len_err;
  logic [15:0] len_err_cnt;

  tcp_rx_notify_reader_if bus();

  tcp_rx_notify_reader #(.NOTIF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .len_err(len_err),
    .len_err_cnt(len_err_cnt)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int rd_seen = 0;
  int tx_seen = 0;
  logic [31:0]  rd_exp[$];
  logic [600:0] tx_exp[$];
  logic [31:0]  rd_act[$];
  logic [600:0] tx_act[$];

  // Inputs change just after posedge, so negedge sees what the next posedge will sample.
  always @(negedge clk) begin
    if (bus.m_axis_read_package_TVALID && bus.m_axis_read_package_TREADY)
      rd_act.push_back(bus.m_axis_read_package_TDATA);
    if (bus.pkt_tx_TVALID && bus.pkt_tx_TREADY)
      tx_act.push_back(bus.pkt_tx_TDATA);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [600:0] obs, input logic [600:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [87:0] mk_notif(input logic [15:0] sess, input logic [15:0] len,
                                           input logic [31:0] ip, input logic [15:0] port,
                                           input logic closed);
    return {7'd0, closed, port, ip, len, sess};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  // Returns one cycle after the handshake cycle (cycle N+1).
  task automatic send_notif(input logic [87:0] n);
    int k;
    k = 0;
    bus.s_axis_notifications_TDATA  = n;
    bus.s_axis_notifications_TVALID = 1'b1;
    while (!bus.s_axis_notifications_TREADY && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("notif_timeout", bus.s_axis_notifications_TREADY, 1'b1);
    tick();
    bus.s_axis_notifications_TVALID = 1'b0;
    if (n[31:16] != 16'd0) rd_exp.push_back(n[31:0]);
  endtask

  task automatic wait_rd(input int target);
    int k;
    k = 0;
    while (rd_act.size() < target && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("wait_rd_timeout", rd_act.size(), target);
  endtask

  task automatic send_beat(input logic [87:0] meta, input logic [511:0] d, input logic last,
                           input bit toggle);
    int k;
    logic hs;
    k = 0;
    hs = 1'b0;
    bus.s_axis_rx_data_TDATA  = d;
    bus.s_axis_rx_data_TLAST  = last;
    bus.s_axis_rx_data_TVALID = 1'b1;
    tx_exp.push_back({last, meta, d});
    while (!hs && k < 100) begin
      if (toggle) bus.pkt_tx_TREADY = ~bus.pkt_tx_TREADY;
      #1;
      if (toggle) chk("rx_rdy_mirror", bus.s_axis_rx_data_TREADY, bus.pkt_tx_TREADY);
      hs = bus.s_axis_rx_data_TREADY;
      @(posedge clk);
      #1;
      k++;
    end
    if (!hs) chk("beat_timeout", hs, 1'b1);
  endtask

  task automatic send_pkt(input logic [87:0] meta, input int nbeats, input bit toggle);
    for (int i = 0; i < nbeats; i++) send_beat(meta, rnd512(), (i == nbeats - 1), toggle);
    bus.s_axis_rx_data_TVALID = 1'b0;
    bus.s_axis_rx_data_TLAST  = 1'b0;
  endtask

  task automatic drain();
    logic [31:0]  er;
    logic [600:0] et;
    while (rd_exp.size() > 0) begin
      er = rd_exp.pop_front();
      if (rd_seen < rd_act.size()) chk("rd_req", rd_act[rd_seen], er);
      else chk("rd_req_missing", rd_act.size(), rd_seen + 1);
      rd_seen++;
    end
    chk("rd_req_count", rd_act.size(), rd_seen);
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front();
      if (tx_seen < tx_act.size()) chk("pkt_tx_beat", tx_act[tx_seen], et);
      else chk("pkt_tx_missing", tx_act.size(), tx_seen + 1);
      tx_seen++;
    end
    chk("pkt_tx_count", tx_act.size(), tx_seen);
  endtask

  initial begin
    logic [87:0] n;
    logic [87:0] nq [5];
    int base;

    rst = 1'b1;
    bus.s_axis_notifications_TDATA  = '0;
    bus.s_axis_notifications_TVALID = 1'b0;
    bus.m_axis_read_package_TREADY  = 1'b1;
    bus.s_axis_rx_data_TDATA        = '0;
    bus.s_axis_rx_data_TLAST        = 1'b0;
    bus.s_axis_rx_data_TVALID       = 1'b0;
    bus.pkt_tx_TREADY               = 1'b1;
    tick();
    tick();
    chk("rst_notif_rdy", bus.s_axis_notifications_TREADY, 1'b0);
    chk("rst_rd_vld", bus.m_axis_read_package_TVALID, 1'b0);
    chk("rst_rd_data", bus.m_axis_read_package_TDATA, 32'd0);
    chk("rst_tx_vld", bus.pkt_tx_TVALID, 1'b0);
    chk("rst_rx_rdy", bus.s_axis_rx_data_TREADY, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_len_err_cnt", len_err_cnt, 16'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_notif_rdy", bus.s_axis_notifications_TREADY, 1'b1);

    // Single 128-byte notification: request at N+2, two beats.
    n = mk_notif(16'h0001, 16'd128, 32'h0A000001, 16'd80, 1'b0);
    send_notif(n);
    chk("t1_req_n1", bus.m_axis_read_package_TVALID, 1'b0);
    tick();
    chk("t1_req_n2", bus.m_axis_read_package_TVALID, 1'b1);
    chk("t1_req_data", bus.m_axis_read_package_TDATA, 32'h00800001);
    wait_rd(1);
    send_pkt(n, 2, 1'b0);
    chk("t1_len_err", len_err, 1'b0);
    drain();

    // Zero-length close: swallowed, FIFO stays empty.
    base = rd_act.size();
    send_notif(mk_notif(16'h0005, 16'd0, 32'h0A000005, 16'd81, 1'b1));
    repeat (4) tick();
    chk("t2_no_req", rd_act.size(), base);
    chk("t2_rd_vld", bus.m_axis_read_package_TVALID, 1'b0);
    n = mk_notif(16'h0002, 16'd64, 32'h0A000002, 16'd82, 1'b0);
    send_notif(n);
    chk("t2_req_n1", bus.m_axis_read_package_TVALID, 1'b0);
    tick();
    chk("t2_req_n2", bus.m_axis_read_package_TVALID, 1'b1);
    wait_rd(base + 1);
    send_pkt(n, 1, 1'b0);
    drain();

    // Five notifications with read requests stalled; a sixth must be refused.
    base = rd_act.size();
    bus.m_axis_read_package_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nq[i] = mk_notif(16'h0010 + 16'(i), 16'(64 * (i + 1)), 32'hC0A80000 + 32'(i), 16'(1000 + i), 1'b0);
      chk("t3_notif_rdy", bus.s_axis_notifications_TREADY, 1'b1);
      send_notif(nq[i]);
    end
    chk("t3_full", bus.s_axis_notifications_TREADY, 1'b0);
    bus.s_axis_notifications_TDATA  = mk_notif(16'h00FF, 16'd64, 32'h0, 16'd0, 1'b0);
    bus.s_axis_notifications_TVALID = 1'b1;
    repeat (3) begin
      tick();
      chk("t3_sixth_refused", bus.s_axis_notifications_TREADY, 1'b0);
    end
    chk("t3_req_held", bus.m_axis_read_package_TDATA, {16'd64, 16'h0010});
    bus.s_axis_notifications_TVALID = 1'b0;
    bus.m_axis_read_package_TREADY  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rd(base + i + 1);
      send_pkt(nq[i], i + 1, 1'b0);
    end
    drain();

    // Four-beat packet with downstream ready toggling every cycle.
    base = rd_act.size();
    n = mk_notif(16'h0033, 16'd256, 32'h0A000033, 16'd83, 1'b0);
    send_notif(n);
    wait_rd(base + 1);
    send_pkt(n, 4, 1'b1);
    bus.pkt_tx_TREADY = 1'b1;
    drain();

    // Length 200 expects 4 beats; tlast arrives on beat 3.
    base = rd_act.size();
    n = mk_notif(16'h0044, 16'd200, 32'h0A000044, 16'd84, 1'b0);
    send_notif(n);
    wait_rd(base + 1);
    send_pkt(n, 3, 1'b0);
    tick();
    chk("t5_len_err", len_err, LEN_CHK);
    chk("t5_len_err_cnt", len_err_cnt, {15'd0, LEN_CHK});
    drain();

    // Reset in the middle of a three-beat packet.
    base = rd_act.size();
    n = mk_notif(16'h0055, 16'd192, 32'h0A000055, 16'd85, 1'b0);
    send_notif(n);
    wait_rd(base + 1);
    send_beat(n, rnd512(), 1'b0, 1'b0);
    bus.s_axis_rx_data_TDATA  = rnd512();
    bus.s_axis_rx_data_TLAST  = 1'b0;
    bus.s_axis_rx_data_TVALID = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rd_vld", bus.m_axis_read_package_TVALID, 1'b0);
    chk("t6_rd_data", bus.m_axis_read_package_TDATA, 32'd0);
    chk("t6_tx_vld", bus.pkt_tx_TVALID, 1'b0);
    chk("t6_rx_rdy", bus.s_axis_rx_data_TREADY, 1'b0);
    chk("t6_notif_rdy", bus.s_axis_notifications_TREADY, 1'b0);
    chk("t6_len_err", len_err, 1'b0);
    chk("t6_len_err_cnt", len_err_cnt, 16'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_rx_held", bus.s_axis_rx_data_TREADY, 1'b0);
    end
    chk("t6_notif_rdy_after", bus.s_axis_notifications_TREADY, 1'b1);
    bus.s_axis_rx_data_TVALID = 1'b0;
    base = rd_act.size();
    n = mk_notif(16'h0066, 16'd64, 32'h0A000066, 16'd86, 1'b0);
    send_notif(n);
    chk("t6_req_n1", bus.m_axis_read_package_TVALID, 1'b0);
    tick();
    chk("t6_req_n2", bus.m_axis_read_package_TVALID, 1'b1);
    chk("t6_req_data", bus.m_axis_read_package_TDATA, 32'h00400066);
    wait_rd(base + 1);
    send_pkt(n, 1, 1'b0);
    repeat (2) tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
